// File: rtl/regfile_wb_buffer.sv
// In-order writeback queue in front of register_file's write port, with youngest-entry forwarding to decode.
// Optional feature: define WB_COALESCE_EN to merge a write into the youngest non-head entry with the same address.
module regfile_wb_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_waddr,
  input  logic [DATA_W-1:0]        in_wdata,
  output logic                     reg_wr,
  output logic [ADDR_W-1:0]        waddr,
  output logic [DATA_W-1:0]        wdata,
  input  logic [ADDR_W-1:0]        fwd_raddr1,
  input  logic [ADDR_W-1:0]        fwd_raddr2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  logic accept;
  logic store;
  logic coalesce;
  logic push;
  logic pop;

  assign in_ready = (count < CNT_W'(DEPTH));
  assign accept   = in_valid & in_ready;
  // x0 writes complete the handshake but are discarded; flush wins over enqueue
  assign store    = accept & (in_waddr != '0) & ~flush;

`ifdef WB_COALESCE_EN
  logic [PTR_W-1:0] tail_m1;
  assign tail_m1  = tail - PTR_W'(1);
  // Youngest entry is the head only when a single entry is held
  assign coalesce = store & (count >= CNT_W'(2)) & (mem_addr[tail_m1] == in_waddr);
`else
  assign coalesce = 1'b0;
`endif

  assign push   = store & ~coalesce;
  assign reg_wr = (count != '0);
  assign pop    = reg_wr;
  assign waddr  = reg_wr ? mem_addr[head] : '0;
  assign wdata  = reg_wr ? mem_data[head] : '0;

  // Walk entries oldest to youngest so the youngest match wins
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    idx       = head;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = head + PTR_W'(i);
      if (vld[idx] && (fwd_raddr1 != '0) && (mem_addr[idx] == fwd_raddr1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = mem_data[idx];
      end
      if (vld[idx] && (fwd_raddr2 != '0) && (mem_addr[idx] == fwd_raddr2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = mem_data[idx];
      end
    end
  end

  // Queue control state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + PTR_W'(1);
      end
      if (push) begin
        vld[tail] <= 1'b1;
        tail      <= tail + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry payload storage; validity is tracked separately so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail] <= in_waddr;
      mem_data[tail] <= in_wdata;
    end
`ifdef WB_COALESCE_EN
    if (coalesce) begin
      mem_data[tail_m1] <= in_wdata;
    end
`endif
  end

endmodule
